// File: rtl/mac_lane_pipe.sv
// rtl/mac_lane_pipe.sv - N-lane pipelined dot-product MAC with accumulate, round/saturate and activation
// Optional: define MAC_LANE_PIPE_SR_EN for LFSR-driven stochastic rounding.
module mac_lane_pipe #(
   parameter int N     = 16,
   parameter int IL    = 4,
   parameter int FL    = 16,
   parameter int GUARD = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N*(IL+FL)-1:0]     in_i,
   input  logic [N*(IL+FL)-1:0]     in_w,
   input  logic                     in_last,
   input  logic [1:0]               in_mode,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [IL+FL-1:0]         out_data,
   output logic                     out_sat
);
   localparam int W  = IL + FL;
   localparam int PW = 2 * W;
   localparam int TW = PW + $clog2(N);
   localparam int AW = TW + GUARD;
   localparam int RW = AW + 1 - FL;

   localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
   localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
   localparam logic signed [W-1:0]  OUT_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0]  OUT_MIN = {1'b1, {(W-1){1'b0}}};
   localparam logic signed [W:0]    ONE     = (W+1)'(1) <<< FL;
   localparam logic signed [W:0]    HALF    = (W+1)'(1) <<< (FL-1);

   logic                 stall;
   logic                 s1_v_q, s1_last_q, s2_v_q, s2_last_q, s3_v_q, s3_last_q;
   logic [1:0]           s1_mode_q, s2_mode_q, s3_mode_q, fin_mode_q;
   logic [N*W-1:0]       s1_a_q, s1_w_q;
   logic signed [PW-1:0] s2_prod_q [N];
   logic signed [TW-1:0] s3_sum_q, sum_d;
   logic signed [AW-1:0] acc_q, acc_d, fin_acc_q;
   logic signed [AW:0]   acc_sum;
   logic                 acc_clip, sticky_q, fin_v_q, fin_sat_q;
   logic                 out_valid_q, out_sat_q, out_clip;
   logic [W-1:0]         out_data_q;
   logic [AW:0]          rc;
   logic signed [AW:0]   rnd_sum;
   logic signed [RW-1:0] rnd;
   logic [RW-W:0]        rnd_hi;
   logic signed [W-1:0]  x, act_d;
   logic signed [W:0]    h_raw, h;
   logic signed [2*W:0]  silu_p;

   // Global stall: a held result freezes every stage, so nothing downstream can be overwritten.
   assign stall     = out_valid_q && !out_ready;
   assign in_ready  = !stall;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;

`ifdef MAC_LANE_PIPE_SR_EN
   localparam int RCW = (FL < 16) ? FL : 16;
   logic [15:0] lfsr_q;

   always_ff @(posedge clk) begin
      if (!reset)
         lfsr_q <= 16'hACE1;
      else if (!stall && fin_v_q)
         lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
   end
   assign rc = (AW+1)'(lfsr_q[15 -: RCW]);
`else
   assign rc = (AW+1)'(1) << (FL-1);
`endif

   always_comb begin
      sum_d = '0;
      for (int k = 0; k < N; k++) sum_d = sum_d + TW'(s2_prod_q[k]);
      acc_sum  = (AW+1)'(acc_q) + (AW+1)'(s3_sum_q);
      acc_clip = acc_sum[AW] != acc_sum[AW-1];
      acc_d    = acc_sum[AW-1:0];
      if (acc_clip) acc_d = acc_sum[AW] ? ACC_MIN : ACC_MAX;
   end

   // Products carry 2*FL fraction bits; rounding drops FL of them to return to Q(IL.FL).
   always_comb begin
      rnd_sum  = $signed((AW+1)'(fin_acc_q) + rc);
      rnd      = RW'(rnd_sum >>> FL);
      rnd_hi   = rnd[RW-1:W-1];
      out_clip = !((&rnd_hi) || !(|rnd_hi));
      x        = rnd[W-1:0];
      if (out_clip) x = rnd[RW-1] ? OUT_MIN : OUT_MAX;
      h_raw = (W+1)'(x >>> 2) + HALF;
      h     = h_raw;
      if (h_raw < 0)
         h = '0;
      else if (h_raw > ONE)
         h = ONE;
      silu_p = x * h;
      case (fin_mode_q)
         2'b01:   act_d = x[W-1] ? '0 : x;
         2'b10:   act_d = W'(silu_p >>> FL);
         default: act_d = x;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_v_q <= 1'b0; s1_last_q <= 1'b0; s1_mode_q <= '0; s1_a_q <= '0; s1_w_q <= '0;
         s2_v_q <= 1'b0; s2_last_q <= 1'b0; s2_mode_q <= '0;
         for (int k = 0; k < N; k++) s2_prod_q[k] <= '0;
         s3_v_q <= 1'b0; s3_last_q <= 1'b0; s3_mode_q <= '0; s3_sum_q <= '0;
         acc_q <= '0; sticky_q <= 1'b0;
         fin_v_q <= 1'b0; fin_acc_q <= '0; fin_sat_q <= 1'b0; fin_mode_q <= '0;
         out_valid_q <= 1'b0; out_data_q <= '0; out_sat_q <= 1'b0;
      end else if (!stall) begin
         s1_v_q    <= in_valid;
         s1_last_q <= in_last;
         s1_mode_q <= in_mode;
         s1_a_q    <= in_i;
         s1_w_q    <= in_w;
         s2_v_q    <= s1_v_q;
         s2_last_q <= s1_last_q;
         s2_mode_q <= s1_mode_q;
         for (int k = 0; k < N; k++)
            s2_prod_q[k] <= $signed(s1_a_q[k*W +: W]) * $signed(s1_w_q[k*W +: W]);
         s3_v_q    <= s2_v_q;
         s3_last_q <= s2_last_q;
         s3_mode_q <= s2_mode_q;
         s3_sum_q  <= sum_d;
         // The last beat hands the finished sum to the output stage and restarts the accumulator.
         if (s3_v_q) begin
            if (s3_last_q) begin
               fin_acc_q  <= acc_d;
               fin_sat_q  <= sticky_q | acc_clip;
               fin_mode_q <= s3_mode_q;
               acc_q      <= '0;
               sticky_q   <= 1'b0;
            end else begin
               acc_q    <= acc_d;
               sticky_q <= sticky_q | acc_clip;
            end
         end
         fin_v_q     <= s3_v_q && s3_last_q;
         out_valid_q <= fin_v_q;
         if (fin_v_q) begin
            out_data_q <= act_d;
            out_sat_q  <= fin_sat_q | out_clip;
         end
      end
   end
endmodule

// File: tb/tb_mac_lane_pipe.sv
// tb/tb_mac_lane_pipe.sv - directed self-checking bench for mac_lane_pipe
module tb_mac_lane_pipe;
   localparam int N = 16, IL = 4, FL = 16, GUARD = 8, W = IL + FL;

   logic           clk = 1'b0, reset = 1'b0;
   logic           in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
   logic [1:0]     in_mode = 2'b00;
   logic [N*W-1:0] in_i = '0, in_w = '0;
   logic           in_ready, out_valid, out_sat;
   logic [W-1:0]   out_data;
   int             n_checks = 0, n_fail = 0;
   logic [W-1:0]   q_data [$];
   logic           q_sat  [$];

   always #5 clk = ~clk;

   mac_lane_pipe #(.N(N), .IL(IL), .FL(FL), .GUARD(GUARD)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_w(in_w),
      .in_last(in_last), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
   );

   // A handshake seen at the falling edge completes on the following rising edge.
   always @(negedge clk)
      if (reset && out_valid && out_ready) begin
         q_data.push_back(out_data);
         q_sat.push_back(out_sat);
      end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic beat(input logic [W-1:0] a, input logic [W-1:0] w, input logic last, input logic [1:0] mode);
      int n = 0;
      in_valid = 1'b1; in_i = {N{a}}; in_w = {N{w}}; in_last = last; in_mode = mode;
      while (!in_ready && n < 50) begin step(); n++; end
      if (!in_ready) check_eq("in_ready_timeout", in_ready, 1);
      step();
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic flush_q();
      q_data.delete();
      q_sat.delete();
   endtask

   task automatic expect_out(input string tag, input int idx, input logic [W-1:0] d, input logic s);
      if (idx < q_data.size()) begin
         check_eq({tag, "_data"}, q_data[idx], d);
         check_eq({tag, "_sat"}, q_sat[idx], s);
      end else
         check_eq({tag, "_missing"}, q_data.size(), idx + 1);
   endtask

   task automatic run1(input string tag, input logic [W-1:0] a, input logic [W-1:0] w,
                       input logic [1:0] mode, input logic [W-1:0] d, input logic s);
      flush_q();
      beat(a, w, 1'b1, mode);
      repeat (8) step();
      check_eq({tag, "_cnt"}, q_data.size(), 1);
      expect_out(tag, 0, d, s);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1'b0;
      repeat (3) step();
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_data", out_data, 0);
      check_eq("rst_out_sat", out_sat, 0);
      reset = 1'b1;
      step();
      check_eq("rst_in_ready", in_ready, 1);

      flush_q();
      beat(20'h04000, 20'h08000, 1'b1, 2'b00);
      n = 0;
      while (!out_valid && n < 20) begin step(); n++; end
      check_eq("latency", n, 4);
      step();
      check_eq("ov_drop", out_valid, 0);
      repeat (3) step();
      check_eq("basic_cnt", q_data.size(), 1);
      expect_out("basic", 0, 20'h20000, 1'b0);

      flush_q();
      beat(20'h04000, 20'h08000, 1'b0, 2'b10);
      beat(20'h04000, 20'h08000, 1'b1, 2'b01);
      repeat (8) step();
      check_eq("multi_cnt", q_data.size(), 1);
      expect_out("multi", 0, 20'h40000, 1'b0);

      flush_q();
      beat(20'h10000, 20'h10000, 1'b0, 2'b00);
      beat(20'h10000, 20'hF0000, 1'b1, 2'b00);
      repeat (8) step();
      check_eq("cancel_cnt", q_data.size(), 1);
      expect_out("cancel", 0, 20'h00000, 1'b0);

      run1("satp",      20'h10000, 20'h10000, 2'b00, 20'h7FFFF, 1'b1);
      run1("satn",      20'h10000, 20'hF0000, 2'b00, 20'h80000, 1'b1);
      run1("satp_relu", 20'h10000, 20'h10000, 2'b01, 20'h7FFFF, 1'b1);
      run1("neg1_id",   20'h10000, 20'hFF000, 2'b00, 20'hF0000, 1'b0);
      run1("neg1_relu", 20'h10000, 20'hFF000, 2'b01, 20'h00000, 1'b0);
      run1("neg1_silu", 20'h10000, 20'hFF000, 2'b10, 20'hFC000, 1'b0);
      run1("two_silu",  20'h04000, 20'h08000, 2'b10, 20'h20000, 1'b0);
      run1("mode3_id",  20'h10000, 20'h01000, 2'b11, 20'h10000, 1'b0);
      run1("rnd_up",    20'h00001, 20'h00800, 2'b00, 20'h00001, 1'b0);
      run1("rnd_neg",   20'h00001, 20'hFF800, 2'b00, 20'h00000, 1'b0);

      flush_q();
      out_ready = 1'b0;
      beat(20'h10000, 20'h01000, 1'b1, 2'b00);
      beat(20'h10000, 20'h02000, 1'b1, 2'b00);
      beat(20'h10000, 20'h03000, 1'b1, 2'b00);
      n = 0;
      while (!out_valid && n < 20) begin step(); n++; end
      check_eq("bp_valid", out_valid, 1);
      for (int c = 0; c < 10; c++) begin
         step();
         check_eq("bp_in_ready", in_ready, 0);
         check_eq("bp_hold_valid", out_valid, 1);
         check_eq("bp_hold_data", out_data, 20'h10000);
      end
      check_eq("bp_none_taken", q_data.size(), 0);
      out_ready = 1'b1;
      repeat (10) step();
      check_eq("bp_cnt", q_data.size(), 3);
      expect_out("bp0", 0, 20'h10000, 1'b0);
      expect_out("bp1", 1, 20'h20000, 1'b0);
      expect_out("bp2", 2, 20'h30000, 1'b0);

      flush_q();
      beat(20'h10000, 20'h10000, 1'b0, 2'b00);
      step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      check_eq("midrst_valid", out_valid, 0);
      beat(20'h04000, 20'h08000, 1'b1, 2'b00);
      repeat (8) step();
      check_eq("midrst_cnt", q_data.size(), 1);
      expect_out("midrst", 0, 20'h20000, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
